// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM states, window base,
// access-size codes and the request-decode helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_e;

    localparam logic [15:0] BRIDGE_BASE = 16'h2000;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // A request goes to APB only when it is a load/store inside the window.
    function automatic logic is_apb_bound(input logic [31:0] addr,
                                          input logic        load,
                                          input logic        store,
                                          input logic [15:0] base);
        return (load | store) && (addr[31:16] == base);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB bus between the bridge (master) and the peripheral address decoder (slave).
interface apb_master_bridge_if;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [1:0]  PSTRB;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic        Pstore_done;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        LOAD_READY;

    modport master (
        output PADDR, PWDATA, PSTRB, PSEL, PENABLE, PWRITE, Pstore_done,
        input  PREADY, PRDATA, LOAD_READY
    );

    modport slave (
        input  PADDR, PWDATA, PSTRB, PSEL, PENABLE, PWRITE, Pstore_done,
        output PREADY, PRDATA, LOAD_READY
    );
endinterface

// File: rtl/apb_timeout_counter.sv
// Counts non-completing ACCESS cycles; expire flags the last allowed one.
module apb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    // Clear on request, otherwise advance once per stalled ACCESS cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // count holds the number of earlier stalled cycles, so +1 is this one.
    assign expire = enable && (({1'b0, count} + 9'd1) == 9'(TIMEOUT_CYCLES));

endmodule

// File: rtl/apb_master_bridge.sv
// APB master: turns core loads/stores in the peripheral window into APB
// transfers and stalls the memory stage until completion or timeout.
module apb_master_bridge #(
    parameter logic [15:0] BRIDGE_BASE    = apb_pkg::BRIDGE_BASE,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [31:0]                CPU_ADDR,
    input  logic [31:0]                CPU_WDATA,
    input  logic [1:0]                 CPU_STRB,
    input  logic                       CPU_LOAD,
    input  logic                       CPU_STORE,
    output logic [31:0]                CPU_RDATA,
    output logic                       CPU_STALL,
    output logic                       CPU_DONE,
    output logic                       CPU_ERR,
    apb_master_bridge_if.master        apb
);
    import apb_pkg::*;

    apb_state_e  state;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic [1:0]  pstrb_q;
    logic        pwrite_q;
    logic        psel_q;
    logic        penable_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        err_q;

    logic apb_req;
    logic complete;
    logic expire;

    assign apb_req  = is_apb_bound(CPU_ADDR, CPU_LOAD, CPU_STORE, BRIDGE_BASE);
    assign complete = (state == ACCESS) && apb.PREADY && (pwrite_q || apb.LOAD_READY);

    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clear  (state == SETUP),
        .enable ((state == ACCESS) && !complete),
        .expire (expire)
    );

    // Transfer FSM; the holding registers double as the APB outputs and are
    // zeroed on leaving ACCESS so the bus reads zero in IDLE and DONE.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (apb_req) begin
                        paddr_q  <= CPU_ADDR;
                        pwdata_q <= CPU_WDATA;
                        pstrb_q  <= CPU_STRB;
                        pwrite_q <= CPU_STORE;
                        psel_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (complete || expire) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        pstrb_q   <= '0;
                        pwrite_q  <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= !complete;
                        rdata_q   <= (complete && !pwrite_q) ? apb.PRDATA : '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign apb.PADDR       = paddr_q;
    assign apb.PWDATA      = pwdata_q;
    assign apb.PSTRB       = pstrb_q;
    assign apb.PWRITE      = pwrite_q;
    assign apb.PSEL        = psel_q;
    assign apb.PENABLE     = penable_q;
    assign apb.Pstore_done = (state == ACCESS) && pwrite_q && apb.PREADY;

    assign CPU_RDATA = rdata_q;
    assign CPU_DONE  = done_q;
    assign CPU_ERR   = err_q;
    assign CPU_STALL = ((state == IDLE) && apb_req) || (state == SETUP) || (state == ACCESS);

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Upstream APB master that converts core load/store requests in the peripheral window (0x2000_xxxx) into APB transfers. Feeds PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/Pstore_done into the peripheral address decoder, consumes its PREADY/PRDATA/LOAD_READY, and stalls the core's memory stage until each transfer completes or times out.

## Interface
Parameters:
- BRIDGE_BASE, 16'h2000, value of CPU_ADDR[31:16] that selects the APB path.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort (1..255, 8-bit counter).

Ports:
- PCLK  in  1  single clock, all state on rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- CPU_ADDR  in  32  request byte address.
- CPU_WDATA  in  32  store data.
- CPU_STRB  in  2  access size: 00 byte, 01 half, 10 word.
- CPU_LOAD  in  1  load request (level).
- CPU_STORE  in  1  store request (level).
- CPU_RDATA  out  32  load data, valid in DONE.
- CPU_STALL  out  1  hold the memory stage.
- CPU_DONE  out  1  one-cycle completion pulse.
- CPU_ERR  out  1  with CPU_DONE: transfer timed out.
- PADDR, PWDATA  out  32  APB address / write data.
- PSTRB  out  2  size code, passed through.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- Pstore_done  out  1  write-commit strobe to slave.
- PREADY  in  1  slave ready.
- PRDATA  in  32  slave read data.
- LOAD_READY  in  1  slave has valid read data.

## Operation
- Request is APB-bound when (CPU_LOAD | CPU_STORE) and CPU_ADDR[31:16]==BRIDGE_BASE; others ignored, no stall.
- CPU_LOAD and CPU_STORE together: treated as store.
- FSM: IDLE → SETUP → ACCESS → DONE → IDLE.
  - IDLE: on APB-bound request, capture addr, wdata, strb, write flag into holding registers; go SETUP.
  - SETUP: PSEL=1, PENABLE=0; unconditionally go ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Completion when PREADY & (PWRITE | LOAD_READY): capture PRDATA (reads) into CPU_RDATA, go DONE. Else increment timeout counter; when counter reaches TIMEOUT_CYCLES without completion, go DONE with error.
  - DONE: PSEL=PENABLE=0, CPU_DONE=1, CPU_ERR=1 on timeout; requests ignored; go IDLE.
- PADDR/PWDATA/PSTRB/PWRITE driven from holding registers in SETUP and ACCESS, held stable throughout; zero in IDLE and DONE.
- Pstore_done = (state==ACCESS) & PWRITE & PREADY (combinational).
- CPU_STALL = (IDLE & APB-bound request) | SETUP | ACCESS; low in DONE.
- CPU_RDATA: loaded on read completion, cleared to 0 on timeout or write completion; holds until next update.
- Timeout counter cleared on entry to SETUP.

## Timing
- Reset (PRESETn low at edge): state IDLE, counter 0, holding regs 0; all outputs 0 (CPU_STALL 0 unless a request is present after reset release).
- Reset mid-transfer: next edge returns to IDLE, PSEL/PENABLE drop immediately; transfer abandoned, no CPU_DONE.
- Zero-wait transfer: request seen cycle 0, SETUP cycle 1, ACCESS cycle 2 with PREADY=1, DONE cycle 3. Stall high cycles 0–2.
- Each PREADY-low (or read with LOAD_READY low) ACCESS cycle adds one cycle.
- Timeout: DONE occurs the cycle after the TIMEOUT_CYCLES-th non-completing ACCESS cycle.
- Completion and timeout in the same cycle: completion wins, CPU_ERR=0.
- Back-to-back: request held through DONE is taken as a new transfer in the following IDLE cycle; minimum 4 cycles per transfer.

## Structure
- Shared package apb_pkg: state encoding (IDLE, SETUP, ACCESS, DONE), BRIDGE_BASE constant, size codes SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module: apb_timeout_counter (clear, enable, terminal-count compare against TIMEOUT_CYCLES).

## Test plan
- Store word 0x1234_5678 to 0x2000_0000, PREADY=1 → SETUP cycle 1, ACCESS cycle 2 with PWRITE=1, Pstore_done=1; CPU_DONE cycle 3, stall high cycles 0–2.
- Load from 0x2000_0004, PREADY=1 for 3 cycles before LOAD_READY=1, PRDATA=0x0000_0041 → ACCESS lasts 4 cycles, CPU_RDATA=0x41 in DONE, CPU_ERR=0.
- Load to 0x1000_0000 → no PSEL, CPU_STALL=0 throughout.
- TIMEOUT_CYCLES=4, PREADY stuck 0 → 4 ACCESS cycles, then DONE with CPU_ERR=1, CPU_RDATA=0.
- PRESETn low during ACCESS → IDLE next edge, PSEL=PENABLE=0, no CPU_DONE; following store completes normally.
- CPU_LOAD and CPU_STORE both high to 0x2000_0008, CPU_STRB=01 → PWRITE=1, PSTRB=01, PADDR/PWDATA stable across SETUP and ACCESS.
